// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan
// Multiplexes six BCD stopwatch digits (MM:SS.hh) onto a 6-digit
// common-anode seven-segment display. The six digits are captured together
// at each frame end, so one frame never mixes two samples. Each slot starts
// with a blanking window to stop ghosting. The display can suppress a
// leading zero, and a lap toggle freezes the shown value while the
// stopwatch keeps running.
module stopwatch_display_scan #(
    parameter int unsigned SLOT_CYCLES  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_10,
    input  logic [3:0] min_1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec_1,
    input  logic [3:0] milli_10,
    input  logic [3:0] milli_1,
    input  logic       lap,
    input  logic       blank_lead,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frozen
);

    localparam int unsigned     CNT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       IDX_LAST  = 3'd5;
    localparam logic [6:0]       SEG_OFF   = 7'h7F;

    // Scan position
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;

    // Frame snapshot; element 0 is min_10, element 5 is milli_1
    logic [5:0][3:0]  r_snap;
    logic [5:0][3:0]  w_live;

    // Lap synchroniser, edge register and hold flag
    logic             r_lap_meta;
    logic             r_lap_sync;
    logic             r_lap_prev;
    logic             r_frozen;

    // Registered display drive
    logic [5:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    // Combinational helpers
    logic             w_slot_end;
    logic             w_frame_end;
    logic             w_lap_rise;
    logic             w_blank;
    logic [5:0]       w_an_sel;
    logic [3:0]       w_digit;
    logic             w_dp_on;
    logic             w_lead_zero;
    logic [6:0]       w_seg_code;

    // BCD to active-low segments (g..a); non-decimal codes show nothing
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Gather the live digits in scan order
    always_comb begin
        w_live[0] = min_10;
        w_live[1] = min_1;
        w_live[2] = sec_10;
        w_live[3] = sec_1;
        w_live[4] = milli_10;
        w_live[5] = milli_1;
    end

    // Slot/frame boundaries, lap edge and blanking window
    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_frame_end = w_slot_end && (r_idx == IDX_LAST);
        w_lap_rise  = r_lap_sync && !r_lap_prev;
        w_blank     = (r_cnt < CNT_BLANK);
    end

    // Select the anode, digit and decimal point for the current slot
    always_comb begin
        w_an_sel = 6'b111111;
        w_digit  = 4'hF;
        w_dp_on  = 1'b0;
        case (r_idx)
            3'd0: begin w_an_sel = 6'b011111; w_digit = r_snap[0]; end
            3'd1: begin w_an_sel = 6'b101111; w_digit = r_snap[1]; w_dp_on = 1'b1; end
            3'd2: begin w_an_sel = 6'b110111; w_digit = r_snap[2]; end
            3'd3: begin w_an_sel = 6'b111011; w_digit = r_snap[3]; w_dp_on = 1'b1; end
            3'd4: begin w_an_sel = 6'b111101; w_digit = r_snap[4]; end
            3'd5: begin w_an_sel = 6'b111110; w_digit = r_snap[5]; end
            default: begin
                w_an_sel = 6'b111111;
                w_digit  = 4'hF;
                w_dp_on  = 1'b0;
            end
        endcase
    end

    // Segment pattern, including leading-zero suppression on the min_10 slot
    always_comb begin
        w_lead_zero = blank_lead && (r_idx == 3'd0) && (r_snap[0] == 4'd0);
        w_seg_code  = w_lead_zero ? SEG_OFF : encode(w_digit);
    end

    // Slot counter and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchroniser plus edge register for the lap button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_meta <= 1'b0;
            r_lap_sync <= 1'b0;
            r_lap_prev <= 1'b0;
        end else begin
            r_lap_meta <= lap;
            r_lap_sync <= r_lap_meta;
            r_lap_prev <= r_lap_sync;
        end
    end

    // Lap hold toggles on each synchronised rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frozen <= 1'b0;
        end else if (w_lap_rise) begin
            r_frozen <= !r_frozen;
        end
    end

    // Frame-coherent capture; uses the pre-edge hold flag, so a freeze on the
    // frame-end edge still loads and an unfreeze waits one more frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap <= '0;
        end else if (w_frame_end && !r_frozen) begin
            r_snap <= w_live;
        end
    end

    // Registered display drive with anti-ghost blanking at the start of each slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_blank) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= w_seg_code;
            r_dp  <= !w_dp_on;
        end
    end

    assign an     = r_an;
    assign seg    = r_seg;
    assign dp     = r_dp;
    assign frozen = r_frozen;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Testbench for stopwatch_display_scan: a cycle-count based reference model
// predicts every output after every edge; directed phases pin specific
// literal values, then a randomized phase exercises digits, lap and reset.
module tb_stopwatch_display_scan;

    localparam int unsigned S = 8;
    localparam int unsigned B = 2;
    localparam int unsigned F = 6 * S;
    localparam logic [6:0] ENC [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] live [6];
    logic       lap = 1'b0;
    logic       blank_lead = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frozen;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state
    int unsigned m = 0;
    int unsigned mcnt;
    int unsigned midx;
    int unsigned qn;
    bit          mtog;
    bit          mf = 1'b0;
    logic [3:0]  msnap [6] = '{default: 4'd0};
    bit          lq [$];
    logic [5:0]  e_an = 6'h3F;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    stopwatch_display_scan #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .min_10     (live[0]),
        .min_1      (live[1]),
        .sec_10     (live[2]),
        .sec_1      (live[3]),
        .milli_10   (live[4]),
        .milli_1    (live[5]),
        .lap        (lap),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frozen     (frozen)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] v);
        return (v < 4'd10) ? ENC[int'(v)] : 7'h7F;
    endfunction

    // Model: position derived from edges since reset; outputs from pre-edge state
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m  = 0;
            mf = 1'b0;
            for (int k = 0; k < 6; k++) msnap[k] = 4'd0;
            lq.delete();
            e_an  = 6'h3F;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            mcnt = m % S;
            midx = (m / S) % 6;
            if (mcnt < B) begin
                e_an  = 6'h3F;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(6'b000001 << (5 - midx));
                e_seg = (blank_lead && midx == 0 && msnap[0] == 4'd0) ? 7'h7F : enc(msnap[midx]);
                e_dp  = !(midx == 1 || midx == 3);
            end
            // frozen toggles three edges after lap is first sampled high
            lq.push_back(lap);
            qn   = lq.size();
            mtog = (qn >= 3) && lq[qn-3] && ((qn < 4) || !lq[qn-4]);
            if ((m % F) == F - 1 && !mf)
                for (int k = 0; k < 6; k++) msnap[k] = live[k];
            if (mtog) mf = !mf;
            m++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        vectors++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp || frozen !== mf) begin
            miscompares++;
            $display("FAIL scan t=%0t m=%0d an=%b exp %b seg=%b exp %b dp=%b exp %b frozen=%b exp %b",
                     $time, m, an, e_an, seg, e_seg, dp, e_dp, frozen, mf);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %b exp %b", name, $time, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Advance until the next edge will be at frame position k (k < F)
    task automatic wait_m(input int unsigned k);
        int unsigned guard;
        guard = 0;
        while ((m % F) != k && guard < 4 * F) begin
            tick(1);
            guard++;
        end
        if ((m % F) != k) begin
            miscompares++;
            $display("FAIL wait_m timeout k=%0d m=%0d", k, m);
        end
    endtask

    task automatic set_live(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        live[0] = a; live[1] = b; live[2] = c; live[3] = d; live[4] = e; live[5] = f;
    endtask

    initial begin
        int unsigned an_low [6];
        int unsigned dp_low;
        set_live(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(13);

        // Mid-slot asynchronous reset, then first frame after release
        #1 reset = 1'b0;
        #1;
        chk("rst_an", an, 6'b111111);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_frozen", frozen, 1'b0);
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("edge1_an", an, 6'b111111);
        @(negedge clk); chk("edge2_seg", seg, 7'h7F);
        @(negedge clk); chk("edge3_an", an, 6'b011111);
        chk("edge3_seg", seg, 7'b1000000);

        // Scan order and decimal points over one captured frame
        set_live(1, 2, 3, 4, 5, 6);
        tick(1);
        wait_m(0);
        @(posedge clk);
        for (int k = 0; k < 6; k++) an_low[k] = 0;
        dp_low = 0;
        for (int c = 0; c < int'(F); c++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) if (!an[k]) an_low[k]++;
            if (!dp) dp_low++;
            if (an == 6'b011111) chk("seg_digit1", seg, 7'b1111001);
        end
        for (int k = 0; k < 6; k++) chk("an_low_cycles", an_low[k], 6);
        chk("dp_low_cycles", dp_low, 12);

        // Coherence: change mid-frame at idx=2, cnt=3
        set_live(0, 0, 0, 0, 0, 0);
        #1; tick(1);
        wait_m(0);
        wait_m(2 * S + 3);
        set_live(9, 9, 9, 9, 9, 9);
        wait_m(4 * S + B + 1);
        @(negedge clk); chk("coh_old", seg, 7'b1000000);
        wait_m(B + 1);
        @(negedge clk); chk("coh_new", seg, 7'b0010000);

        // Lap hold of 05:42.17
        set_live(0, 5, 4, 2, 1, 7);
        tick(1);
        wait_m(0);
        tick(5);
        lap = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("lap_e1", frozen, 1'b0);
        @(negedge clk); chk("lap_e2", frozen, 1'b0);
        @(negedge clk); chk("lap_e3", frozen, 1'b1);
        tick(17);
        lap = 1'b0;
        repeat (4) begin
            for (int k = 0; k < 6; k++) live[k] = 4'($urandom_range(0, 9));
            tick(F / 2 + 3);
        end
        wait_m(S + B + 1);
        @(negedge clk); chk("hold_min1", seg, 7'b0010010);
        lap = 1'b1;
        tick(6);
        lap = 1'b0;
        tick(2 * F);

        // Leading zero and invalid code
        blank_lead = 1'b1;
        set_live(0, 3, 1, 4'hC, 2, 8);
        tick(1); wait_m(0); wait_m(B + 1);
        @(negedge clk); chk("lz_an", an, 6'b011111);
        chk("lz_seg", seg, 7'h7F);
        wait_m(3 * S + B + 1);
        @(negedge clk); chk("inv_an", an, 6'b111011);
        chk("inv_seg", seg, 7'h7F);
        live[0] = 4'd3;
        tick(1); wait_m(0); wait_m(B + 1);
        @(negedge clk); chk("lz3_seg", seg, 7'b0110000);
        blank_lead = 1'b0;

        // Freeze toggling on the frame-end edge still captures that frame
        set_live(8, 1, 2, 3, 4, 5);
        tick(1);
        wait_m(F - 3);
        lap = 1'b1;
        tick(4);
        lap = 1'b0;
        chk("sim_frozen", frozen, 1'b1);
        set_live(6, 6, 6, 6, 6, 6);
        wait_m(B + 1);
        @(negedge clk); chk("sim_capture", seg, 7'b0000000);
        // Unfreeze on a frame-end edge: next frame still shows the held value
        tick(1);
        wait_m(F - 3);
        lap = 1'b1;
        tick(4);
        lap = 1'b0;
        chk("unf_frozen", frozen, 1'b0);
        wait_m(B + 1);
        @(negedge clk); chk("unf_held", seg, 7'b0000000);
        tick(1);
        wait_m(0);
        wait_m(B + 1);
        @(negedge clk); chk("unf_new", seg, 7'b0000010);

        // Randomized traffic with one asynchronous reset
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                int unsigned k;
                k = $urandom_range(0, 5);
                live[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 39) == 0) lap = ~lap;
            if ($urandom_range(0, 199) == 0) blank_lead = ~blank_lead;
            if (i == 1200) begin
                #1 reset = 1'b0;
                #1;
                chk("rnd_rst_an", an, 6'b111111);
                tick(2);
                reset = 1'b1;
            end
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
